// File: rtl/eval_stack.sv
// eval_stack: 32-bit operand stack for the bytecode core.
// A LIFO built from a single-port synchronous RAM and an occupancy pointer,
// served through a one-request-at-a-time trigger/done handshake.
// Optional feature: define EVAL_STACK_ERR_EN to build a sticky overflow /
// underflow flag on 'err'; without it 'err' is tied low.

module eval_stack #(
  parameter  int DEPTH = 256,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          evaltrigger,
  input  logic          evalpush,
  input  logic [31:0]   evalwrite,
  output logic [31:0]   evalread,
  output logic          evaldone,
  output logic [PW-1:0] sp,
  output logic          empty,
  output logic          full,
  output logic          err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [PW-1:0] SP_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] SP_ONE  = PW'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] sp_q, sp_d;
  logic          done_q, done_d;
  logic          push_q, push_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   read_q;

  logic          inAccess;
  logic          pushOk;
  logic          popOk;
  logic          popEmpty;
  logic [PW-1:0] spDec;
  logic [AW-1:0] memAddr;

  logic [31:0]   mem [DEPTH];

  // Occupancy flags follow the pointer directly so they move with sp.
  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_FULL);

  assign inAccess = (state_q == ACCESS);
  assign pushOk   = inAccess &  push_q & ~full;
  assign popOk    = inAccess & ~push_q & ~empty;
  assign popEmpty = inAccess & ~push_q &  empty;

  // One RAM port: pushes write at the pointer, pops read the entry below it.
  assign spDec    = sp_q - SP_ONE;
  assign memAddr  = push_q ? sp_q[AW-1:0] : spDec[AW-1:0];

  // Next-state logic: a request is only taken in IDLE, ACCESS always finishes.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    done_d  = 1'b0;
    push_d  = push_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (evaltrigger) begin
          push_d  = evalpush;
          data_d  = evalwrite;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (pushOk) begin
          sp_d = sp_q + SP_ONE;
        end else if (popOk) begin
          sp_d = spDec;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered handshake; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= '0;
      done_q  <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      done_q  <= done_d;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end

  // RAM write port; contents survive reset, but an aborted push never lands.
  always_ff @(posedge clk) begin
    if (!rst && pushOk) begin
      mem[memAddr] <= data_q;
    end
  end

  // RAM read port doubles as the popped-word register; an empty pop reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_q <= '0;
    end else if (popOk) begin
      read_q <= mem[memAddr];
    end else if (popEmpty) begin
      read_q <= '0;
    end
  end

`ifdef EVAL_STACK_ERR_EN
  logic guardHit;
  logic err_q;

  assign guardHit = inAccess & (push_q ? full : empty);

  // Sticky flag raised by any dropped push or empty pop, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (guardHit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign evalread = read_q;
  assign evaldone = done_q;
  assign sp       = sp_q;

endmodule

// File: doc/eval_stack.md
# eval_stack

Operand (evaluation) stack for the bytecode core: a LIFO of 32-bit words that serves the control unit's push/pop requests over a single trigger/done handshake. It sits directly beside the control FSM, which requests:

- pops for ALU operands, comparison operands and local-variable stores;
- pushes for constants, literals, loads and ALU results.

Storage is a synchronous single-port RAM plus a stack pointer. Occupancy flags are exported for debug and for the method-call logic.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit entries; power of two, ≥ 4
- PW, $clog2(DEPTH)+1, stack-pointer width (derived; not overridden)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- evaltrigger  in  1  request strobe; sampled only while FSM is IDLE
- evalpush  in  1  1 = push, 0 = pop; sampled with evaltrigger
- evalwrite  in  32  push data; sampled with evaltrigger
- evalread  out  32  popped word; valid from evaldone cycle until next accepted pop
- evaldone  out  1  one-cycle completion pulse
- sp  out  PW  current occupancy, 0..DEPTH
- empty  out  1  sp == 0
- full  out  1  sp == DEPTH
- err  out  1  sticky overflow/underflow flag (see Configuration)

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - If evaltrigger=1, latch evalpush and evalwrite, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS, push:
  - Not full: mem[sp] <= data; sp <= sp+1.
  - Full: write suppressed; sp unchanged.
- ACCESS, pop:
  - Not empty: evalread <= mem[sp-1]; sp <= sp-1.
  - Empty: evalread <= 0; sp unchanged.
- ACCESS always returns to IDLE and sets evaldone <= 1 for exactly one cycle.
- evaltrigger is ignored while in ACCESS. Requests are never queued.
- A push does not modify evalread.
- Stored data is not cleared by rst; only sp is.
- Reset values: state=IDLE, sp=0, evalread=0, evaldone=0, err=0, empty=1, full=0.
- rst during ACCESS: the operation is aborted and no evaldone is produced. The abort must not alter any of the reset values.

## Timing
- Request seen in cycle T (evaltrigger=1 with state IDLE).
- Cycle T+1: ACCESS; RAM read/write and sp update at the end of T+1.
- Cycle T+2: evaldone=1 and evalread valid; sp, empty and full already updated; state is IDLE.
- A new evaltrigger in T+2 is accepted, giving back-to-back operations every 2 cycles.
- Control clears evaltrigger after one cycle. A trigger held high across T+1 is not double-counted.
- empty and full are combinational from sp. They change in the same cycle as sp.
- Pointer arithmetic is unsigned PW-bit. sp never exceeds DEPTH and never wraps below 0.

## Configuration
- Macro: EVAL_STACK_ERR_EN.
- Defined:
  - err is set in the ACCESS cycle of a push-when-full or a pop-when-empty. It becomes visible alongside that operation's evaldone.
  - err holds until rst.
  - The offending op still completes with evaldone, and the guard behaviour above still applies.
- Undefined:
  - err is tied to 0.
  - Guard behaviour is unchanged: the push is dropped, or the pop returns 0.
  - No error register is synthesised.

## Test plan
- **Reset and basic push/pop:** after rst, push 0x0000_0005, then pop → evaldone 2 cycles after each trigger; evalread=0x0000_0005; sp goes 0→1→0; empty ends at 1.
- **LIFO order back-to-back:** push 0x11, 0x22, 0x33 with a trigger issued in each evaldone cycle, then 3 pops → reads 0x33, 0x22, 0x11; evaldone pulses exactly 6 times, 2 cycles apart.
- **Full boundary (DEPTH=4):** 5 pushes of 1..5 → full=1 after the 4th; the 5th is dropped with sp=4. Then 4 pops return 4,3,2,1. err=1 with the macro, 0 without.
- **Empty boundary:** pop on an empty stack → evaldone pulses, evalread=0, sp=0. err=1 with the macro and stays 1 through subsequent valid ops until rst.
- **Trigger while busy:** trigger held high for 2 cycles on a push → exactly one push (sp+1) and one evaldone.
- **Reset mid-operation:** push 0xAB, then assert rst during the ACCESS cycle → no evaldone; sp=0, err=0, evalread=0. The next push/pop pair behaves normally.
